bus_datapath_seq: RTL and testbench

BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

---
 rtl/bus_datapath_seq.sv | 188 ++++++++++++++++++
 tb/tb_bus_datapath_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq
// A multi-cycle single-bus register-file datapath. Each accepted command takes
// three internal steps (T1..T3) over one shared bus: the first operand goes into
// the Y latch, the ALU result goes into the Z latch, and Z is written back.
// One command completes every four cycles.
//
// Parameters:
//   WIDTH  register and bus width in bits (8..64)
//   NREGS  number of general registers (power of two, 4..32)
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous reset, active low
//   cmd_valid/cmd_ready   command handshake; ready is high only in IDLE
//   cmd_op                000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                         101 MOV, 110 LDI, 111 OUT
//   cmd_ra/cmd_rb/cmd_rc  destination, source B and source C register numbers
//   cmd_imm               immediate value for LDI
//   out_port              registered output written by OUT
//   done                  one-cycle pulse in the cycle after T3
//   flag_zero/flag_carry  result flags, updated at the write-back edge
//   dbg_addr/dbg_data     combinational register-file read port
//
// Build option:
//   BUS_DATAPATH_R0_ZERO_EN  when defined, R0 always reads as zero and writes
//                            to it are dropped
`timescale 1ns/1ps

module bus_datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [AW-1:0]    cmd_rc,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] out_port,
    output logic             done,
    output logic             flag_zero,
    output logic             flag_carry,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_OUT = 3'b111;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [AW-1:0]    ra_q;
    logic [AW-1:0]    rb_q;
    logic [AW-1:0]    rc_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             carry_pend;
    logic [WIDTH-1:0] regs [NREGS];

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] rb_data;
    logic [WIDTH-1:0] rc_data;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign cmd_ready = (state == IDLE);

    // Register-file read ports; with the zero-register option R0 is hardwired to 0
`ifdef BUS_DATAPATH_R0_ZERO_EN
    assign rb_data  = (rb_q == '0)     ? '0 : regs[rb_q];
    assign rc_data  = (rc_q == '0)     ? '0 : regs[rc_q];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`else
    assign rb_data  = regs[rb_q];
    assign rc_data  = regs[rc_q];
    assign dbg_data = regs[dbg_addr];
`endif

    // Single shared bus: whichever source the current step needs drives it
    always_comb begin
        bus = '0;
        case (state)
            T1:      bus = (op_q == OP_LDI) ? imm_q : rb_data;
            T2:      bus = rc_data;
            T3:      bus = z;
            default: bus = '0;
        endcase
    end

    // ALU combines the Y latch with the bus; the extra top bit of the
    // subtraction is the borrow
    assign sum  = {1'b0, y} + {1'b0, bus};
    assign diff = {1'b0, y} - {1'b0, bus};

    always_comb begin
        alu_res   = y;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  {alu_carry, alu_res} = sum;
            OP_SUB:  {alu_carry, alu_res} = diff;
            OP_AND:  alu_res = y & bus;
            OP_OR:   alu_res = y | bus;
            OP_XOR:  alu_res = y ^ bus;
            default: alu_res = y;
        endcase
    end

    // Sequencer and all architectural state. The carry is held aside from T2 so
    // that both flags change together at the write-back edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            imm_q      <= '0;
            y          <= '0;
            z          <= '0;
            carry_pend <= 1'b0;
            out_port   <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        ra_q  <= cmd_ra;
                        rb_q  <= cmd_rb;
                        rc_q  <= cmd_rc;
                        imm_q <= cmd_imm;
                        state <= T1;
                    end
                end
                T1: begin
                    y     <= bus;
                    state <= T2;
                end
                T2: begin
                    z          <= alu_res;
                    carry_pend <= alu_carry;
                    state      <= T3;
                end
                default: begin
                    if (op_q == OP_OUT) begin
                        out_port <= bus;
                    end else begin
`ifdef BUS_DATAPATH_R0_ZERO_EN
                        if (ra_q != '0) begin
                            regs[ra_q] <= bus;
                        end
`else
                        regs[ra_q] <= bus;
`endif
                    end
                    flag_zero  <= (bus == '0);
                    flag_carry <= carry_pend;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq
// Scoreboard bench for bus_datapath_seq. The stimulus process issues commands,
// computes each command's effect on an arithmetic model of the register file
// and queues the expected result. A separate monitor pops one entry on every
// done pulse and compares flags, out_port, completion time and the whole
// register file via the debug read port.
`timescale 1ns/1ps

module tb_bus_datapath_seq;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int AW    = 4;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_OP = 3'd2, OR_OP = 3'd3;
    localparam logic [2:0] XOR_OP = 3'd4, MOV = 3'd5, LDI = 3'd6, OUT = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [AW-1:0]    cmd_ra = '0;
    logic [AW-1:0]    cmd_rb = '0;
    logic [AW-1:0]    cmd_rc = '0;
    logic [WIDTH-1:0] cmd_imm = '0;
    logic [WIDTH-1:0] out_port;
    logic             done;
    logic             flag_zero;
    logic             flag_carry;
    logic [AW-1:0]    dbg_addr = '0;
    logic [WIDTH-1:0] dbg_data;

    bus_datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
        .cmd_imm(cmd_imm),
        .out_port(out_port), .done(done),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time acceptances and completions
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREGS-1:0][WIDTH-1:0] regs;
        logic [WIDTH-1:0]            outv;
        logic                        fz;
        logic                        fc;
        int unsigned                 due;
    } exp_t;

    exp_t             sb [$];
    logic [WIDTH-1:0] mregs [NREGS];
    logic [WIDTH-1:0] mout;
    int               total = 0;
    int               bad = 0;
    int unsigned      last_acc = 0;
    bit               chain = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mrd(input logic [AW-1:0] a);
`ifdef BUS_DATAPATH_R0_ZERO_EN
        if (a == 0) return '0;
`endif
        return mregs[a];
    endfunction

    // Reference behaviour of one whole command, computed straight from the
    // instruction semantics
    task automatic model_cmd(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [AW-1:0] rc, input logic [WIDTH-1:0] imm, input int unsigned acc);
        logic [WIDTH-1:0] b, c, res;
        logic [WIDTH:0]   wide;
        logic             cy;
        exp_t             e;
        b  = (op == LDI) ? imm : mrd(rb);
        c  = mrd(rc);
        cy = 1'b0;
        case (op)
            ADD:    begin wide = {1'b0, b} + {1'b0, c}; res = wide[WIDTH-1:0]; cy = wide[WIDTH]; end
            SUB:    begin res = b - c; cy = (b < c); end
            AND_OP: res = b & c;
            OR_OP:  res = b | c;
            XOR_OP: res = b ^ c;
            default: res = b;
        endcase
        if (op == OUT) mout = res;
`ifdef BUS_DATAPATH_R0_ZERO_EN
        else if (ra != 0) mregs[ra] = res;
`else
        else mregs[ra] = res;
`endif
        for (int i = 0; i < NREGS; i++) e.regs[i] = mregs[i];
        e.outv = mout;
        e.fz   = (res == 0);
        e.fc   = cy;
        e.due  = acc + 3;
        sb.push_back(e);
    endtask

    // Issue one command starting at a falling edge. While the DUT is busy the
    // command fields carry junk with valid high, which must be ignored.
    task automatic apply_stimulus(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                  input logic [AW-1:0] rc, input logic [WIDTH-1:0] imm,
                                  input bit keep, input bit expect_done);
        int          busy = 0;
        int unsigned acc;
        cmd_valid = 1'b1;
        while (!cmd_ready && busy < 20) begin
            cmd_op  = 3'($urandom);
            cmd_ra  = AW'($urandom);
            cmd_rb  = AW'($urandom);
            cmd_rc  = AW'($urandom);
            cmd_imm = $urandom;
            @(negedge clk);
            busy++;
        end
        if (!cmd_ready) begin
            check_output("ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            chain = 1'b0;
            return;
        end
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
        acc = cyc + 1;
        if (chain) begin
            check_output("accept_gap", 64'(acc - last_acc), 64'd4);
            check_output("busy_cycles", 64'(busy), 64'd3);
        end
        last_acc = acc;
        chain = keep;
        if (expect_done) model_cmd(op, ra, rb, rc, imm, acc);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) check_output("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("done_cycle", 64'(cyc), 64'(e.due));
                    check_output("out_port", 64'(out_port), 64'(e.outv));
                    check_output("flag_zero", 64'(flag_zero), 64'(e.fz));
                    check_output("flag_carry", 64'(flag_carry), 64'(e.fc));
                    for (int i = 0; i < NREGS; i++) begin
                        dbg_addr = AW'(i);
                        #0.2;
                        check_output($sformatf("reg%0d", i), 64'(dbg_data), 64'(e.regs[i]));
                    end
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] imm;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        mout = '0;

        // Power-on reset
        #12;
        check_output("rst_out_port", 64'(out_port), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_flag_zero", 64'(flag_zero), 64'd0);
        check_output("rst_flag_carry", 64'(flag_carry), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Simple add
        apply_stimulus(LDI, 4'd1, 4'd0, 4'd0, 32'h0000_0005, 1'b0, 1'b1);
        apply_stimulus(LDI, 4'd2, 4'd0, 4'd0, 32'h0000_0003, 1'b0, 1'b1);
        apply_stimulus(ADD, 4'd3, 4'd1, 4'd2, 32'h0, 1'b0, 1'b1);

        // Carry, borrow and zero boundaries
        apply_stimulus(LDI, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        apply_stimulus(LDI, 4'd2, 4'd0, 4'd0, 32'h0000_0001, 1'b0, 1'b1);
        apply_stimulus(ADD, 4'd4, 4'd1, 4'd2, 32'h0, 1'b0, 1'b1);
        apply_stimulus(SUB, 4'd5, 4'd2, 4'd1, 32'h0, 1'b0, 1'b1);

        // Destination aliasing both sources, then OUT
        apply_stimulus(LDI, 4'd6, 4'd0, 4'd0, 32'h0F0F_0F0F, 1'b0, 1'b1);
        apply_stimulus(XOR_OP, 4'd6, 4'd6, 4'd6, 32'h0, 1'b0, 1'b1);
        apply_stimulus(OUT, 4'd9, 4'd3, 4'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Valid held high across three back-to-back commands
        apply_stimulus(LDI, 4'd10, 4'd0, 4'd0, 32'h1234_5678, 1'b1, 1'b1);
        apply_stimulus(ADD, 4'd11, 4'd10, 4'd3, 32'h0, 1'b1, 1'b1);
        apply_stimulus(OR_OP, 4'd12, 4'd11, 4'd6, 32'h0, 1'b0, 1'b1);
        wait_drain();

        // Reset while an ADD into R7 is in its second step
        apply_stimulus(ADD, 4'd7, 4'd1, 4'd2, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("abort_out_port", 64'(out_port), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        check_output("abort_flag_zero", 64'(flag_zero), 64'd0);
        check_output("abort_flag_carry", 64'(flag_carry), 64'd0);
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        mout = '0;
        chain = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_output("ready_after_abort", 64'(cmd_ready), 64'd1);

        // R0 behaviour depends on the build option
        apply_stimulus(LDI, 4'd0, 4'd0, 4'd0, 32'h0000_1234, 1'b0, 1'b1);
        apply_stimulus(ADD, 4'd13, 4'd0, 4'd0, 32'h0, 1'b0, 1'b1);

        // Randomized mix, including immediates at the extremes
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       imm = '0;
                1:       imm = '1;
                default: imm = $urandom;
            endcase
            apply_stimulus(3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom), AW'($urandom),
                           imm, 1'($urandom_range(0, 1)), 1'b1);
            if (!chain) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
